// File: rtl/envelope_follower.sv
`default_nettype none
// ============================================================================
// Module      : envelope_follower
// Description : Recovers the amplitude envelope of an offset-binary sample
//               stream using an attack/hold/release follower, plus a hysteretic gate.
// Revision    : 1.0 - initial release
// ============================================================================
module envelope_follower #(
    parameter int BITDEPTH     = 14,
    parameter int VOLBITS      = 8,
    parameter int HOLD_SAMPLES = 256
) (
    input  logic                sample_clock,
    input  logic                rst_n,
    input  logic [BITDEPTH-1:0] in,
    input  logic                in_valid,
    input  logic [7:0]          attack,
    input  logic [7:0]          release_step,
    input  logic [VOLBITS-1:0]  threshold_on,
    input  logic [VOLBITS-1:0]  threshold_off,
    output logic [VOLBITS-1:0]  level,
    output logic                level_valid,
    output logic                gate
);

    localparam int                  c_ENV_W = 2 * VOLBITS;
    localparam int                  c_MAG_W = BITDEPTH - 1;
    localparam logic [BITDEPTH-1:0] c_MID   = BITDEPTH'(1) << (BITDEPTH - 1);
    localparam logic [15:0]         c_HOLD  = 16'(HOLD_SAMPLES);

    typedef enum logic [1:0] {
        S_TRACK   = 2'd0,
        S_ATTACK  = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_s1_valid;
    logic [VOLBITS-1:0]   r_mag8;
    logic [c_ENV_W-1:0]   r_env;
    logic [c_ENV_W-1:0]   w_env_next;
    logic [15:0]          r_hold;
    logic [15:0]          w_hold_next;
    logic                 r_level_valid;
    logic                 r_gate;
    logic                 w_gate_next;

    logic [BITDEPTH-1:0]  w_mag_full;
    logic [c_MAG_W-1:0]   w_mag;
    logic [VOLBITS-1:0]   w_mag8;
    logic [VOLBITS-1:0]   w_cur_level;
    logic [VOLBITS-1:0]   w_new_level;
    logic [c_ENV_W:0]     w_target;
    logic [c_ENV_W:0]     w_env_ext;
    logic [c_ENV_W:0]     w_up;
    logic [c_ENV_W:0]     w_dn_sat;

    // Stage 1: magnitude about the midpoint; full negative scale clamps to max positive
    always_comb begin
        if (in >= c_MID) begin
            w_mag_full = in - c_MID;
        end else begin
            w_mag_full = c_MID - in;
        end
        if (w_mag_full[BITDEPTH-1]) begin
            w_mag = '1;
        end else begin
            w_mag = w_mag_full[c_MAG_W-1:0];
        end
        w_mag8 = w_mag[c_MAG_W-1 -: VOLBITS];
    end

    assign w_cur_level = r_env[c_ENV_W-1 -: VOLBITS];
    assign w_target    = {1'b0, r_mag8, VOLBITS'(0)};
    assign w_env_ext   = {1'b0, r_env};
    assign w_up        = w_env_ext + (c_ENV_W + 1)'(attack);
    assign w_dn_sat    = ((c_ENV_W + 1)'(release_step) > w_env_ext) ? '0
                       : w_env_ext - (c_ENV_W + 1)'(release_step);

    // Stage 2: follower state machine; a rising target always wins over hold/release
    always_comb begin
        w_env_next   = r_env;
        w_state_next = r_state;
        w_hold_next  = r_hold;
        if (r_mag8 > w_cur_level) begin
            if (attack == 8'd0 || w_up >= w_target) begin
                w_env_next = w_target[c_ENV_W-1:0];
            end else begin
                w_env_next = w_up[c_ENV_W-1:0];
            end
            w_state_next = S_ATTACK;
            w_hold_next  = 16'd0;
        end else if (r_mag8 == w_cur_level) begin
            w_state_next = S_TRACK;
            w_hold_next  = 16'd0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold < c_HOLD) begin
                        w_hold_next = r_hold + 16'd1;
                    end else begin
                        w_state_next = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (release_step == 8'd0 || w_dn_sat <= w_target) begin
                        w_env_next   = w_target[c_ENV_W-1:0];
                        w_state_next = S_TRACK;
                    end else begin
                        w_env_next = w_dn_sat[c_ENV_W-1:0];
                    end
                end
                default: begin
                    w_state_next = S_HOLD;
                    w_hold_next  = 16'd1;
                end
            endcase
        end
    end

    assign w_new_level = w_env_next[c_ENV_W-1 -: VOLBITS];

    always_comb begin
        w_gate_next = r_gate;
        if (!r_gate && w_new_level >= threshold_on) begin
            w_gate_next = 1'b1;
        end else if (r_gate && w_new_level < threshold_off) begin
            w_gate_next = 1'b0;
        end
    end

    always_ff @(posedge sample_clock) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_mag8        <= '0;
            r_env         <= '0;
            r_state       <= S_TRACK;
            r_hold        <= 16'd0;
            r_level_valid <= 1'b0;
            r_gate        <= 1'b0;
        end else begin
            r_s1_valid    <= in_valid;
            r_level_valid <= r_s1_valid;
            if (in_valid) begin
                r_mag8 <= w_mag8;
            end
            if (r_s1_valid) begin
                r_env   <= w_env_next;
                r_state <= w_state_next;
                r_hold  <= w_hold_next;
                r_gate  <= w_gate_next;
            end
        end
    end

    assign level       = w_cur_level;
    assign level_valid = r_level_valid;
    assign gate        = r_gate;

endmodule
`default_nettype wire

// File: tb/tb_envelope_follower.sv
`default_nettype none
// ============================================================================
// Module      : tb_envelope_follower
// Description : Scoreboard bench for envelope_follower against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_envelope_follower;

    localparam int BITDEPTH     = 14;
    localparam int VOLBITS      = 8;
    localparam int HOLD_SAMPLES = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [13:0]  in;
    logic         in_valid;
    logic [7:0]   attack;
    logic [7:0]   release_step;
    logic [7:0]   thr_on;
    logic [7:0]   thr_off;
    logic [7:0]   level;
    logic         level_valid;
    logic         gate;

    always #5 clk = ~clk;

    envelope_follower #(
        .BITDEPTH     (BITDEPTH),
        .VOLBITS      (VOLBITS),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) dut (
        .sample_clock  (clk),
        .rst_n         (rst_n),
        .in            (in),
        .in_valid      (in_valid),
        .attack        (attack),
        .release_step  (release_step),
        .threshold_on  (thr_on),
        .threshold_off (thr_off),
        .level         (level),
        .level_valid   (level_valid),
        .gate          (gate)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int lvl;
        int gt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Model: phase 0 track, 1 attack, 2 hold, 3 release
    int m_env, m_hold, m_phase, m_gate;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic model_push(input int sample);
        int s, mag, mag8, t, lvl;
        exp_t e;
        s   = sample - 8192;
        mag = (s < 0) ? -s : s;
        if (mag > 8191) mag = 8191;
        mag8 = mag / 32;
        t    = mag8 * 256;
        lvl  = m_env / 256;
        if (mag8 > lvl) begin
            if (attack == 0 || m_env + attack > t) m_env = t;
            else m_env = m_env + attack;
            m_phase = 1;
            m_hold  = 0;
        end else if (mag8 == lvl) begin
            m_phase = 0;
            m_hold  = 0;
        end else if (m_phase == 2) begin
            if (m_hold < HOLD_SAMPLES) m_hold++;
            else m_phase = 3;
        end else if (m_phase == 3) begin
            m_env = (release_step == 0) ? t : m_env - release_step;
            if (m_env <= t) begin
                m_env   = t;
                m_phase = 0;
            end
        end else begin
            m_phase = 2;
            m_hold  = 1;
        end
        lvl = m_env / 256;
        if (m_gate == 0 && lvl >= thr_on) m_gate = 1;
        else if (m_gate == 1 && lvl < thr_off) m_gate = 0;
        e.due = cyc + 2;
        e.lvl = lvl;
        e.gt  = m_gate;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int sample);
        in       = 14'(sample);
        in_valid = 1'b1;
        model_push(sample);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_n(input int sample, input int n);
        for (int i = 0; i < n; i++) drive(sample);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        @(negedge clk); #1;
        sb_q.delete();
        m_env = 0; m_hold = 0; m_phase = 0; m_gate = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            check_eq("rst_level", level, 0);
            check_eq("rst_gate", gate, 0);
            check_eq("rst_valid", level_valid, 0);
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (level_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("valid_cycle", cyc, mon_e.due);
                check_eq("sb_level", level, mon_e.lvl);
                check_eq("sb_gate", gate, mon_e.gt);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            check_eq("missing_valid", 0, 1);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: timeout observed cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in = 14'd16383; in_valid = 1'b1;
        attack = 8'd0; release_step = 8'd0; thr_on = 8'd100; thr_off = 8'd50;

        // Reset with a full-scale sample held on the input
        apply_reset(3);
        drive(16383);
        drain();
        check_eq("t1_level", level, 255);

        // Instantaneous attack and idle stability
        apply_reset(1);
        drive(12288);
        @(posedge clk); #1;
        check_eq("t2_valid_n2", level_valid, 1);
        check_eq("t2_level", level, 128);
        @(posedge clk); #1;
        check_eq("t2_valid_drop", level_valid, 0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t2_idle_level", level, 128);

        // Slow attack ramp to full scale
        apply_reset(1);
        attack = 8'd16;
        drive_n(16383, 160);
        drain();
        check_eq("t3_level_160", level, 10);
        drive_n(16383, 3920);
        drain();
        check_eq("t3_level_full", level, 255);
        drive_n(16383, 20);
        drain();
        check_eq("t3_no_overflow", level, 255);

        // Negative full-scale clamp
        apply_reset(1);
        attack = 8'd0;
        drive(0);
        drive(1);
        drive(8191);
        drain();
        check_eq("t4_clamp", level, 255);

        // Hold then release, interrupted by attack
        apply_reset(1);
        attack = 8'd0;
        drive(12288);
        drain();
        release_step = 8'd64;
        drive_n(8192, 256);
        drain();
        check_eq("t5_hold_256", level, 128);
        drive(8192);
        drain();
        check_eq("t5_hold_257", level, 128);
        drive(8192);
        drain();
        check_eq("t5_first_step", level, 127);
        drive_n(8192, 300);
        drive(8192 + 200 * 32);
        drain();
        check_eq("t5_reattack", level, 200);
        drive_n(8192, 1100);
        drain();
        check_eq("t5_release_zero", level, 0);

        // Gate hysteresis on an attack then release ramp
        apply_reset(1);
        thr_on = 8'd100; thr_off = 8'd50; attack = 8'd64; release_step = 8'd64;
        drive_n(16383, 399);
        drain();
        check_eq("t6_gate_99", gate, 0);
        check_eq("t6_level_99", level, 99);
        drive(16383);
        drain();
        check_eq("t6_gate_100", gate, 1);
        drive_n(16383, 100);
        while (m_env / 256 > 60) drive(8192);
        drain();
        check_eq("t6_level_60", level, 60);
        check_eq("t6_gate_60", gate, 1);
        while (m_env / 256 > 50) drive(8192);
        drain();
        check_eq("t6_gate_50", gate, 1);
        while (m_env / 256 > 49) drive(8192);
        drain();
        check_eq("t6_level_49", level, 49);
        check_eq("t6_gate_49", gate, 0);

        // Reset in the middle of a back-to-back ramp
        drive_n(16383, 20);
        apply_reset(1);

        // Inverted thresholds: opens when closed, closes on the next sample
        attack = 8'd0; thr_on = 8'd50; thr_off = 8'd100;
        drive(8192 + 60 * 32);
        drive(8192 + 60 * 32);
        drive(8192 + 120 * 32);
        drain();
        check_eq("t7_gate_inverted", gate, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
